serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Multi-cycle controller that time-shares one 4-bit adder to add or subtract wide operands, nibble by nibble, LSB first, with carry chained through a register. It sits between a requester issuing start/operands and the 4-bit adder datapath. It trades latency for area on the EP4CE10 and reports completion with a busy/done handshake.

## Interface
- NIBBLES, 4: operand width in nibbles (W = 4*NIBBLES bits); legal 2..16.
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- op_sub  in  1  0 = a+b+c_in, 1 = a-b; latched with start.
- a  in  W  operand A; latched with start.
- b  in  W  operand B; latched with start.
- c_in  in  1  carry in for add; ignored when op_sub=1.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse: result valid.
- sum  out  W  result; held until next done.
- c_out  out  1  carry out of MSB; in subtract mode this is NOT-borrow.
- ovf  out  1  signed (two's-complement) overflow.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: on start=1, latch a, b, op_sub, c_in; b_eff = op_sub ? ~b : b; carry_reg = op_sub ? 1 : c_in; idx = 0; go to RUN.
- RUN: adder input is nibble idx of a_reg, b_eff, and carry_reg. At each edge:
  - write result nibble into accumulator position idx;
  - carry_reg <= adder carry out;
  - idx++.
  - After nibble NIBBLES-1, go to DONE.
- DONE: sum <= accumulator, c_out <= carry_reg, ovf <= (a_msb == b_eff_msb) && (sum_msb != a_msb); done=1 for this cycle; next state IDLE.
- start in RUN or DONE is ignored; it is neither queued nor able to corrupt latched operands.
- sum/c_out/ovf change only on entry to DONE; they are stable during RUN.
- Arithmetic is modulo 2^W; no saturation.

## Timing
- Reset values: busy=0, done=0, sum=0, c_out=0, ovf=0, state=IDLE, idx=0, carry_reg=0.
- Reset takes effect asynchronously. rst_n low mid-RUN aborts immediately: outputs go to reset values, no done pulse. The first start after release is accepted normally.
- Start sampled at edge E0. busy is high from E0 to E(NIBBLES). done and the new result are visible from E(NIBBLES) to E(NIBBLES+1).
- Latency from start edge to done: NIBBLES cycles.
- IDLE is re-entered at E(NIBBLES+1). With start held high, back-to-back operations occur every NIBBLES+2 cycles.
- done never coincides with busy.

## Structure
- Shared package serial_add_pkg holds:
  - state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - NIB_W=4;
  - the idx width function (clog2 of NIBBLES).
- One sub-module, add4_core: purely combinational 4-bit ripple adder (a[3:0], b[3:0], ci → s[3:0], co), instantiated once.
- The controller owns all registers: operand latches, accumulator, carry_reg, idx, and the FSM.

## Test plan
All scenarios use NIBBLES=4.
- Add 0x1234 + 0x0FFF, c_in=0 → sum=0x2233, c_out=0, ovf=0; done exactly 4 cycles after the start edge; busy high for 4 cycles.
- Add 0xFFFF + 0x0001, c_in=0 → sum=0x0000, c_out=1, ovf=0. Same operands with c_in=1 → sum=0x0001, c_out=1.
- Add 0x7FFF + 0x0001 → sum=0x8000, c_out=0, ovf=1. Add 0x8000 + 0x8000 → sum=0x0000, c_out=1, ovf=1.
- Subtract 0x0005 - 0x0007 (c_in=1, must be ignored) → sum=0xFFFE, c_out=0, ovf=0. Subtract 0x0007 - 0x0005 → sum=0x0002, c_out=1.
- Start 0x1111 + 0x2222, then pulse start with 0xAAAA + 0x5555 during RUN cycle 2 → sum=0x3333, single done pulse, second request dropped. sum stays at the previous result until done.
- Drive rst_n low during RUN cycle 2 → busy/sum/c_out/ovf=0 immediately, no done pulse. After release, 0x0F0F + 0x0101 → sum=0x1010 with normal latency.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared definitions for the nibble-serial add/subtract controller:
// FSM encoding, nibble width and the nibble-index width helper.
package serial_add_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A 1-wide index is kept as the floor so a single-nibble build still elaborates.
  function automatic int idx_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/add4_core.sv
// Purely combinational 4-bit ripple-carry adder; the only arithmetic
// element shared across all nibbles of an operation.
module add4_core
  import serial_add_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             ci,
  output logic [NIB_W-1:0] s,
  output logic             co
);

  logic c;

  always_comb begin
    c = ci;
    s = '0;
    for (int i = 0; i < NIB_W; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Wide add/subtract done LSB-nibble first through one 4-bit adder, with the
// carry chained between nibbles through carry_reg.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     op_sub,
  input  logic [NIB_W*NIBBLES-1:0] a,
  input  logic [NIB_W*NIBBLES-1:0] b,
  input  logic                     c_in,
  output logic                     busy,
  output logic                     done,
  output logic [NIB_W*NIBBLES-1:0] sum,
  output logic                     c_out,
  output logic                     ovf,
  output logic [1:0]               dbg_state
);

  localparam int W  = NIB_W * NIBBLES;
  localparam int IW = idx_width(NIBBLES);

  // Handshake: start is taken only in IDLE (edge E0); busy is high for the
  // NIBBLES RUN cycles; done pulses for exactly one cycle with sum/c_out/ovf
  // already valid, and never overlaps busy. start outside IDLE is dropped.

  state_t          state, state_nx;
  logic [W-1:0]    a_reg, b_reg, acc, acc_nx;
  logic            carry_reg;
  logic [IW-1:0]   idx;
  logic [NIB_W-1:0] nib_a, nib_b, nib_s;
  logic            nib_co;
  logic            last_nib;

  assign nib_a    = a_reg[int'(idx)*NIB_W +: NIB_W];
  assign nib_b    = b_reg[int'(idx)*NIB_W +: NIB_W];
  assign last_nib = (idx == IW'(NIBBLES - 1));

  add4_core u_add4 (
    .a  (nib_a),
    .b  (nib_b),
    .ci (carry_reg),
    .s  (nib_s),
    .co (nib_co)
  );

  always_comb begin
    acc_nx = acc;
    acc_nx[int'(idx)*NIB_W +: NIB_W] = nib_s;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last_nib) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // b_reg holds the effective B operand (inverted for subtract, +1 via carry).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      acc       <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      sum       <= '0;
      c_out     <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg     <= a;
            b_reg     <= op_sub ? ~b : b;
            carry_reg <= op_sub ? 1'b1 : c_in;
            acc       <= '0;
            idx       <= '0;
          end
        end
        RUN: begin
          acc       <= acc_nx;
          carry_reg <= nib_co;
          idx       <= idx + IW'(1);
          if (last_nib) begin
            idx   <= '0;
            sum   <= acc_nx;
            c_out <= nib_co;
            ovf   <= (a_reg[W-1] == b_reg[W-1]) && (nib_s[NIB_W-1] != a_reg[W-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl (NIBBLES=4): directed arithmetic corners, start
// interference, mid-run reset, back-to-back and random traffic vs a model.
module tb_serial_add_ctrl;

  localparam int NIBBLES = 4;
  localparam int W       = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         op_sub = 1'b0;
  logic         c_in = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, c_out, ovf;
  logic [W-1:0] sum;
  logic [1:0]   dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [W+1:0] exp_q[$];   // {ovf, c_out, sum}
  logic [W-1:0] last_sum = '0;

  serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op_sub    (op_sub),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: integer arithmetic on the operands' unsigned and signed values.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, mb, input logic msub, mcin);
    int unsigned ua, ub, us;
    int          sa, sb, r;
    logic        co, ov;
    ua = ma;
    ub = mb;
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    if (msub) begin
      us = ua - ub;
      r  = sa - sb;
      co = (ua >= ub);
    end else begin
      us = ua + ub + int'(mcin);
      r  = sa + sb + int'(mcin);
      co = (us > 32'd65535);
    end
    ov = (r > 32767) || (r < -32768);
    return {ov, co, us[W-1:0]};
  endfunction

  task automatic issue(input logic [W-1:0] ia, ib, input logic isub, icin);
    @(negedge clk);
    a = ia; b = ib; op_sub = isub; c_in = icin; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    exp_q.push_back(model(ia, ib, isub, icin));
    // Scramble the inputs so results depend only on the latched operands.
    a = W'($urandom); b = W'($urandom); op_sub = 1'($urandom); c_in = 1'($urandom);
  endtask

  // Follows one operation from the start edge to its done pulse and checks it.
  task automatic check_op(input string name, input int inject);
    logic [W+1:0] exp;
    int lat, busy_cnt;
    bit seen, stable, overlap;
    seen = 0; lat = -1; busy_cnt = 0; stable = 1; overlap = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (i == inject) begin
        start = 1'b1; a = 16'hAAAA; b = 16'h5555; op_sub = 1'b0; c_in = 1'b0;
      end else if (i == inject + 1) begin
        start = 1'b0;
      end
      if (done) begin
        seen = 1; lat = i;
        if (busy) overlap = 1;
      end else begin
        if (busy) busy_cnt++;
        if (sum !== last_sum) stable = 0;
      end
    end
    start = 1'b0;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s timeout: no done within 20 cycles", name);
      return;
    end
    n_cmp++; if (lat !== NIBBLES) begin n_err++; $display("FAIL %s latency: got %0d want %0d", name, lat, NIBBLES); end
    n_cmp++; if (busy_cnt !== NIBBLES) begin n_err++; $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_cnt, NIBBLES); end
    n_cmp++; if (!stable) begin n_err++; $display("FAIL %s sum_stable: sum changed before done (want %h)", name, last_sum); end
    n_cmp++; if (overlap) begin n_err++; $display("FAIL %s done_busy: got busy=1 with done want busy=0", name); end
    n_cmp++; if (sum !== exp[W-1:0]) begin n_err++; $display("FAIL %s sum: got %h want %h", name, sum, exp[W-1:0]); end
    n_cmp++; if (c_out !== exp[W]) begin n_err++; $display("FAIL %s c_out: got %b want %b", name, c_out, exp[W]); end
    n_cmp++; if (ovf !== exp[W+1]) begin n_err++; $display("FAIL %s ovf: got %b want %b", name, ovf, exp[W+1]); end
    last_sum = exp[W-1:0];
    @(negedge clk);
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0 || dbg_state !== 2'd0) begin
      n_err++; $display("FAIL %s after_done: got done=%b busy=%b state=%0d want 0/0/0", name, done, busy, dbg_state);
    end
    n_cmp++; if (sum !== exp[W-1:0]) begin n_err++; $display("FAIL %s sum_hold: got %h want %h", name, sum, exp[W-1:0]); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || c_out !== 1'b0 || ovf !== 1'b0 || dbg_state !== 2'd0) begin
      n_err++;
      $display("FAIL reset: got busy=%b done=%b sum=%h c_out=%b ovf=%b state=%0d want all 0",
               busy, done, sum, c_out, ovf, dbg_state);
    end
    rst_n = 1'b1;
    last_sum = '0;
    @(negedge clk);
  endtask

  task automatic test_add();
    issue(16'h1234, 16'h0FFF, 1'b0, 1'b0); check_op("add_1234_0fff", -1);
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0); check_op("add_ffff_0001", -1);
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b1); check_op("add_ffff_0001_cin", -1);
  endtask

  task automatic test_overflow();
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0); check_op("ovf_7fff_0001", -1);
    issue(16'h8000, 16'h8000, 1'b0, 1'b0); check_op("ovf_8000_8000", -1);
    issue(16'h8000, 16'h0001, 1'b1, 1'b0); check_op("ovf_sub_8000_0001", -1);
  endtask

  task automatic test_sub();
    issue(16'h0005, 16'h0007, 1'b1, 1'b1); check_op("sub_0005_0007", -1);
    issue(16'h0007, 16'h0005, 1'b1, 1'b0); check_op("sub_0007_0005", -1);
  endtask

  task automatic test_ignore_start();
    issue(16'h1111, 16'h2222, 1'b0, 1'b0);
    check_op("ignore_start", 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        n_err++; $display("FAIL ignore_start_queued: got busy=%b done=%b want 0/0 at idle cycle %0d", busy, done, i);
      end
    end
  endtask

  task automatic test_abort_reset();
    bit saw_done;
    issue(16'hBEEF, 16'h1357, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || c_out !== 1'b0 || ovf !== 1'b0 || dbg_state !== 2'd0) begin
      n_err++;
      $display("FAIL abort_reset: got busy=%b done=%b sum=%h c_out=%b ovf=%b state=%0d want all 0",
               busy, done, sum, c_out, ovf, dbg_state);
    end
    exp_q.delete();
    last_sum = '0;
    saw_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    n_cmp++;
    if (saw_done) begin n_err++; $display("FAIL abort_no_done: got done pulse want none"); end
    issue(16'h0F0F, 16'h0101, 1'b0, 1'b0); check_op("after_abort", -1);
  endtask

  task automatic test_back_to_back();
    logic [W+1:0] exp;
    int dones[$];
    logic [W-1:0] ra, rb;
    ra = W'($urandom); rb = W'($urandom);
    exp = model(ra, rb, 1'b0, 1'b1);
    @(negedge clk);
    a = ra; b = rb; op_sub = 1'b0; c_in = 1'b1; start = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done) begin
        dones.push_back(i);
        n_cmp++;
        if (sum !== exp[W-1:0] || c_out !== exp[W] || ovf !== exp[W+1]) begin
          n_err++; $display("FAIL b2b_result: got %h/%b/%b want %h/%b/%b", sum, c_out, ovf, exp[W-1:0], exp[W], exp[W+1]);
        end
      end
    end
    start = 1'b0;
    n_cmp++;
    if (dones.size() !== 2) begin
      n_err++; $display("FAIL b2b_count: got %0d done pulses want 2", dones.size());
    end else begin
      n_cmp++;
      if (dones[0] !== NIBBLES || dones[1] - dones[0] !== NIBBLES + 2) begin
        n_err++; $display("FAIL b2b_period: got first=%0d gap=%0d want %0d/%0d", dones[0], dones[1] - dones[0], NIBBLES, NIBBLES + 2);
      end
    end
    repeat (10) @(negedge clk);
    last_sum = exp[W-1:0];
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb;
    logic rs, rc;
    for (int n = 0; n < 24; n++) begin
      ra = W'($urandom); rb = W'($urandom);
      rs = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
      if (n % 6 == 0) ra = {1'b0, {(W-1){1'b1}}};
      issue(ra, rb, rs, rc);
      check_op($sformatf("random_%0d", n), -1);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_overflow();
    test_sub();
    test_ignore_start();
    test_abort_reset();
    test_back_to_back();
    test_random();
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_err++; $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
